// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: command, status and sample-RAM write signals of the
// capture sequencer, bundled so the controller and its host/RAM side
// connect through a single port.
//   start, stop, clr_cap_done  host commands
//   trig_pos                   post-trigger sample count (0 behaves as 1)
//   en                         decimated sample strobe
//   triggered                  trigger unit output
//   armed                      arm enable back to the trigger unit
//   set_capture_done           one-cycle completion pulse (clears trigger unit)
//   capture_done               completion status level
//   we, waddr                  sample RAM write port
//   trig_addr                  address of the last sample of the finished capture
// Modports: slave = the capture controller, master = everything driving it.
interface capture_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] trig_pos;
  logic              en;
  logic              triggered;
  logic              clr_cap_done;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;

  modport slave (
    input  start, stop, trig_pos, en, triggered, clr_cap_done,
    output armed, set_capture_done, capture_done, we, waddr, trig_addr
  );

  modport master (
    output start, stop, trig_pos, en, triggered, clr_cap_done,
    input  armed, set_capture_done, capture_done, we, waddr, trig_addr
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one acquisition of the circular sample RAM around
// the trigger unit. After start it writes one RAM entry per sample strobe,
// arms the trigger once enough pre-trigger history is stored, counts the
// programmed number of post-trigger samples, then pulses set_capture_done and
// latches the final write address for readout unrolling.
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    capture_ctrl_if.slave (commands, strobes, status, RAM write port)
module capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_SUM = (ADDR_W + 2)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] waddr_q,     waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   smpl_cnt_q,  smpl_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q,  post_cnt_d;
  logic              set_done_q,  set_done_d;

  logic [ADDR_W-1:0] tp_s;
  logic [ADDR_W+1:0] arm_sum_s;
  logic              run_en_s;
  logic              complete_s;

  // Effective post-trigger count, arm threshold and completion detect.
  always_comb begin
    tp_s       = (bus.trig_pos == {ADDR_W{1'b0}}) ? ONE_ADDR : bus.trig_pos;
    // Two extra bits so history + post-count can never wrap.
    arm_sum_s  = {1'b0, smpl_cnt_q} + {2'b00, tp_s};
    run_en_s   = (state_q == ST_RUN) && bus.en;
    complete_s = run_en_s && bus.triggered && (post_cnt_q == (tp_s - ONE_ADDR));
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    set_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          waddr_d    = {ADDR_W{1'b0}};
          smpl_cnt_d = {(ADDR_W + 1){1'b0}};
          post_cnt_d = {ADDR_W{1'b0}};
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The RAM write happens on any en cycle in RUN, including the
        // completion cycle and a cycle where stop aborts.
        if (bus.en) begin
          waddr_d = (waddr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : (waddr_q + ONE_ADDR);
          if (smpl_cnt_q != DEPTH_CNT) begin
            smpl_cnt_d = smpl_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            smpl_cnt_d = smpl_cnt_q;
          end
          if (bus.triggered) begin
            post_cnt_d = post_cnt_q + ONE_ADDR;
          end else begin
            post_cnt_d = post_cnt_q;
          end
        end else begin
          waddr_d = waddr_q;
        end
        // Abort wins over a simultaneous completion.
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (complete_s) begin
          trig_addr_d = waddr_q;
          set_done_d  = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.clr_cap_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      waddr_q     <= {ADDR_W{1'b0}};
      trig_addr_q <= {ADDR_W{1'b0}};
      smpl_cnt_q  <= {(ADDR_W + 1){1'b0}};
      post_cnt_q  <= {ADDR_W{1'b0}};
      set_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      set_done_q  <= set_done_d;
    end
  end

  assign bus.we               = run_en_s;
  assign bus.armed            = (state_q == ST_RUN) && (arm_sum_s >= DEPTH_SUM);
  assign bus.set_capture_done = set_done_q;
  assign bus.capture_done     = (state_q == ST_DONE);
  assign bus.waddr            = waddr_q;
  assign bus.trig_addr        = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl with
// ADDR_W=4, DEPTH=16. Inputs change 2 time units after the rising edge and
// outputs are sampled 1 unit later, well away from the next edge.
module tb_capture_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  capture_ctrl_if #(.ADDR_W(4)) bus ();

  capture_ctrl #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_cap_done = 1'b1;
    step();
    bus.clr_cap_done = 1'b0;
  endtask

  initial begin
    int ens;
    int trig_ens;
    int exp_w;
    logic en_now;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.trig_pos = 4'd0;
    bus.en = 1'b0; bus.triggered = 1'b0; bus.clr_cap_done = 1'b0;

    // Reset state
    #1;
    check("rst_armed", 32'(bus.armed), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_setdone", 32'(bus.set_capture_done), 32'd0);
    check("rst_capdone", 32'(bus.capture_done), 32'd0);
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    check("rst_trigaddr", 32'(bus.trig_addr), 32'd0);
    #20 rst_n = 1'b1;
    step();

    // Case 2/3: trig_pos=4, en every cycle, trigger on the en at waddr=5
    bus.trig_pos = 4'd4;
    pulse_start();
    for (int k = 1; k <= 25; k++) begin
      bus.en = 1'b1;
      bus.triggered = (k >= 22);
      #1;
      check($sformatf("c2_waddr_%0d", k), 32'(bus.waddr), 32'((k - 1) % 16));
      check($sformatf("c2_we_%0d", k), 32'(bus.we), 32'd1);
      check($sformatf("c2_armed_%0d", k), 32'(bus.armed), 32'((k - 1) >= 12));
      check($sformatf("c2_setdone_%0d", k), 32'(bus.set_capture_done), 32'd0);
      step();
    end
    #1;
    check("c3_setdone", 32'(bus.set_capture_done), 32'd1);
    check("c3_capdone", 32'(bus.capture_done), 32'd1);
    check("c3_trigaddr", 32'(bus.trig_addr), 32'd8);
    check("c3_we_done", 32'(bus.we), 32'd0);
    check("c3_armed_done", 32'(bus.armed), 32'd0);
    step();
    bus.en = 1'b0; bus.triggered = 1'b0;
    #1;
    check("c3_setdone_1cyc", 32'(bus.set_capture_done), 32'd0);
    check("c3_capdone_hold", 32'(bus.capture_done), 32'd1);
    pulse_start();
    #1;
    check("c3_start_in_done", 32'(bus.capture_done), 32'd1);
    check("c3_waddr_kept", 32'(bus.waddr), 32'd9);
    pulse_clr();
    #1;
    check("c3_capdone_clr", 32'(bus.capture_done), 32'd0);

    // Case 4: en every 3rd cycle, trig_pos=2, trigger once 14 samples stored
    bus.trig_pos = 4'd2;
    pulse_start();
    ens = 0; trig_ens = 0; exp_w = 0;
    for (int c = 0; c < 80 && trig_ens < 2; c++) begin
      en_now = ((c % 3) == 0);
      bus.en = en_now;
      bus.triggered = (ens >= 14);
      #1;
      check($sformatf("c4_waddr_%0d", c), 32'(bus.waddr), 32'(exp_w % 16));
      check($sformatf("c4_we_%0d", c), 32'(bus.we), 32'(en_now));
      check($sformatf("c4_armed_%0d", c), 32'(bus.armed), 32'((ens + 2) >= 16));
      check($sformatf("c4_setdone_%0d", c), 32'(bus.set_capture_done), 32'd0);
      if (en_now) begin
        if (ens >= 14) trig_ens++;
        ens++;
        exp_w++;
      end
      step();
    end
    bus.en = 1'b0; bus.triggered = 1'b0;
    #1;
    check("c4_setdone", 32'(bus.set_capture_done), 32'd1);
    check("c4_capdone", 32'(bus.capture_done), 32'd1);
    check("c4_trigaddr", 32'(bus.trig_addr), 32'd15);
    pulse_clr();

    // Case 5: trig_pos=0 acts as 1
    bus.trig_pos = 4'd0;
    pulse_start();
    for (int k = 1; k <= 18; k++) begin
      bus.en = 1'b1;
      bus.triggered = (k == 18);
      #1;
      check($sformatf("c5_armed_%0d", k), 32'(bus.armed), 32'((k - 1) >= 15));
      check($sformatf("c5_waddr_%0d", k), 32'(bus.waddr), 32'((k - 1) % 16));
      step();
    end
    bus.en = 1'b0; bus.triggered = 1'b0;
    #1;
    check("c5_setdone", 32'(bus.set_capture_done), 32'd1);
    check("c5_capdone", 32'(bus.capture_done), 32'd1);
    check("c5_trigaddr", 32'(bus.trig_addr), 32'd1);
    pulse_clr();

    // Case 6: stop coincides with completion
    bus.trig_pos = 4'd1;
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      bus.en = 1'b1;
      bus.triggered = (k == 4);
      bus.stop = (k == 4);
      #1;
      check($sformatf("c6_waddr_%0d", k), 32'(bus.waddr), 32'(k - 1));
      step();
    end
    bus.stop = 1'b0; bus.triggered = 1'b0; bus.en = 1'b1;
    #1;
    check("c6_setdone", 32'(bus.set_capture_done), 32'd0);
    check("c6_capdone", 32'(bus.capture_done), 32'd0);
    check("c6_trigaddr", 32'(bus.trig_addr), 32'd1);
    check("c6_we_idle", 32'(bus.we), 32'd0);
    step();
    #1;
    check("c6_setdone_late", 32'(bus.set_capture_done), 32'd0);
    bus.en = 1'b0;
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      bus.en = 1'b1;
      #1;
      check($sformatf("c6r_waddr_%0d", k), 32'(bus.waddr), 32'(k - 1));
      check($sformatf("c6r_armed_%0d", k), 32'(bus.armed), 32'((k - 1) >= 15));
      step();
    end

    // Case 1: asynchronous reset in the middle of RUN
    #1;
    check("c1_armed_pre", 32'(bus.armed), 32'd1);
    rst_n = 1'b0;
    #1;
    check("c1_armed", 32'(bus.armed), 32'd0);
    check("c1_we", 32'(bus.we), 32'd0);
    check("c1_waddr", 32'(bus.waddr), 32'd0);
    check("c1_trigaddr", 32'(bus.trig_addr), 32'd0);
    check("c1_setdone", 32'(bus.set_capture_done), 32'd0);
    check("c1_capdone", 32'(bus.capture_done), 32'd0);
    #3 rst_n = 1'b1;
    step();
    #1;
    check("c1_idle_we", 32'(bus.we), 32'd0);
    check("c1_idle_waddr", 32'(bus.waddr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
